// File: rtl/bp_resolve_unit.sv
// ---------------------------------------------------------------------------
// bp_resolve_unit
//
// Execute-side checker for the fetch-stage branch predictor. Every prediction
// issued at fetch is recorded in a small in-order FIFO. Each branch resolved in
// execute is compared with the oldest record. On a mismatch the unit sends a
// one-cycle redirect/train pulse back to fetch, pulses flush and discards all
// younger predictions. Hit and miss statistics are kept for perf counters.
//
// Handshake: pd_valid is a one-sided push request. It is accepted only in RUN
// and only when the FIFO has room (or the head pops in the same cycle). A push
// into a full FIFO without a pop is dropped; fetch is expected to stall on
// pd_full. ex_valid is an unconditional resolve request and is ignored while
// the unit is flushing.
//
// Ports:
//   clk, resetn               clock, synchronous active-low reset
//   pd_valid/pd_pc/pd_bus     prediction push {bp_e, bp_target} for a delay-slot PC
//   ex_valid/ex_pc/ex_taken/ex_target   resolved branch outcome
//   br_bus                    registered {br_e, br_target} redirect pulse
//   delayslot_pc              registered PC belonging to the last redirect
//   flush                     one-cycle pulse coincident with br_e
//   pd_full, pd_empty         FIFO status
//   resolve_cnt, miss_cnt     statistics, wrap at 2^32
// ---------------------------------------------------------------------------
module bp_resolve_unit #(
    parameter int DEPTH     = 4,
    parameter int BR_WD     = 33,
    parameter int FLUSH_CYC = 1
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             pd_valid,
    input  logic [31:0]      pd_pc,
    input  logic [BR_WD-1:0] pd_bus,
    input  logic             ex_valid,
    input  logic [31:0]      ex_pc,
    input  logic             ex_taken,
    input  logic [31:0]      ex_target,
    output logic [BR_WD-1:0] br_bus,
    output logic [31:0]      delayslot_pc,
    output logic             flush,
    output logic             pd_full,
    output logic             pd_empty,
    output logic [31:0]      resolve_cnt,
    output logic [31:0]      miss_cnt
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int TW = BR_WD - 1;
    localparam int EW = 32 + BR_WD;           // entry = {pc, bp_e, bp_target}
    localparam int FW = $clog2(FLUSH_CYC + 1);

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [FW-1:0]     fcnt_q, fcnt_d;
    logic [EW-1:0]     mem_q [DEPTH];
    logic [EW-1:0]     mem_d [DEPTH];
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [BR_WD-1:0]  br_bus_q, br_bus_d;
    logic [31:0]       dpc_q, dpc_d;
    logic              flush_q, flush_d;
    logic [31:0]       resolve_cnt_q, resolve_cnt_d;
    logic [31:0]       miss_cnt_q, miss_cnt_d;

    logic              run, empty, full, resolve, pop, push, pred_ok, miss;
    logic [EW-1:0]     head;
    logic              head_bpe;
    logic [TW-1:0]     head_tgt;
    logic [31:0]       head_pc;

    assign run     = (state_q == ST_RUN);
    assign empty   = (cnt_q == '0);
    assign full    = (cnt_q == CW'(DEPTH));
    assign head    = mem_q[rd_ptr_q];
    // An empty FIFO behaves like a "not taken" record for the resolving PC.
    assign head_bpe = empty ? 1'b0 : head[BR_WD-1];
    assign head_tgt = head[TW-1:0];
    assign head_pc  = empty ? ex_pc : head[EW-1 -: 32];

    assign resolve = ex_valid & run;
    assign pop     = resolve & ~empty;
    assign push    = pd_valid & run & (~full | pop);
    assign pred_ok = ex_taken ? (head_bpe & (head_tgt == TW'(ex_target))) : ~head_bpe;
    // A PC mismatch means fetch and execute lost sync: always redirect.
    assign miss    = resolve & ((head_pc != ex_pc) | ~pred_ok);

    always_comb begin
        mem_d         = mem_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        cnt_d         = cnt_q;
        state_d       = state_q;
        fcnt_d        = fcnt_q;
        br_bus_d      = '0;
        dpc_d         = dpc_q;
        flush_d       = 1'b0;
        resolve_cnt_d = resolve_cnt_q + {31'd0, resolve};
        miss_cnt_d    = miss_cnt_q;

        if (push) begin
            mem_d[wr_ptr_q] = {pd_pc, pd_bus};
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase

        if (state_q == ST_FLUSH) begin
            fcnt_d = fcnt_q - FW'(1);
            if (fcnt_q == FW'(1)) begin
                state_d = ST_RUN;
            end
        end

        // A miss wipes the FIFO, overriding any push or pop of this cycle.
        if (miss) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            cnt_d      = '0;
            state_d    = ST_FLUSH;
            fcnt_d     = FW'(FLUSH_CYC);
            br_bus_d   = {1'b1, TW'(ex_taken ? ex_target : ex_pc + 32'd4)};
            dpc_d      = ex_pc;
            flush_d    = 1'b1;
            miss_cnt_d = miss_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q       <= ST_RUN;
            fcnt_q        <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            cnt_q         <= '0;
            br_bus_q      <= '0;
            dpc_q         <= '0;
            flush_q       <= 1'b0;
            resolve_cnt_q <= '0;
            miss_cnt_q    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q       <= state_d;
            fcnt_q        <= fcnt_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            cnt_q         <= cnt_d;
            br_bus_q      <= br_bus_d;
            dpc_q         <= dpc_d;
            flush_q       <= flush_d;
            resolve_cnt_q <= resolve_cnt_d;
            miss_cnt_q    <= miss_cnt_d;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    assign br_bus       = br_bus_q;
    assign delayslot_pc = dpc_q;
    assign flush        = flush_q;
    assign pd_full      = full;
    assign pd_empty     = empty;
    assign resolve_cnt  = resolve_cnt_q;
    assign miss_cnt     = miss_cnt_q;

endmodule

// File: tb/tb_bp_resolve_unit.sv
// ---------------------------------------------------------------------------
// tb_bp_resolve_unit
//
// Directed scenarios with literal expectations, then randomized traffic.
// A queue-based model of the prediction FIFO computes the expected outputs
// after every clock edge; a negedge process compares the DUT to it.
// ---------------------------------------------------------------------------
module tb_bp_resolve_unit;

  localparam int DEPTH     = 4;
  localparam int BR_WD     = 33;
  localparam int FLUSH_CYC = 1;

  // clock / reset
  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  logic             pd_valid = 1'b0;
  logic [31:0]      pd_pc = '0;
  logic [BR_WD-1:0] pd_bus = '0;
  logic             ex_valid = 1'b0;
  logic [31:0]      ex_pc = '0;
  logic             ex_taken = 1'b0;
  logic [31:0]      ex_target = '0;
  logic [BR_WD-1:0] br_bus;
  logic [31:0]      delayslot_pc;
  logic             flush;
  logic             pd_full;
  logic             pd_empty;
  logic [31:0]      resolve_cnt;
  logic [31:0]      miss_cnt;

  bp_resolve_unit #(.DEPTH(DEPTH), .BR_WD(BR_WD), .FLUSH_CYC(FLUSH_CYC)) dut (
    .clk(clk), .resetn(resetn),
    .pd_valid(pd_valid), .pd_pc(pd_pc), .pd_bus(pd_bus),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_taken(ex_taken), .ex_target(ex_target),
    .br_bus(br_bus), .delayslot_pc(delayslot_pc), .flush(flush),
    .pd_full(pd_full), .pd_empty(pd_empty),
    .resolve_cnt(resolve_cnt), .miss_cnt(miss_cnt)
  );

  // behavioural model
  typedef struct {
    logic [31:0] pc;
    logic        bpe;
    logic [31:0] tgt;
  } rec_t;

  rec_t        q[$];
  int          flush_left = 0;
  logic [32:0] m_br = '0;
  logic [31:0] m_dpc = '0;
  logic        m_flush = 1'b0;
  logic [31:0] m_res = '0;
  logic [31:0] m_miss = '0;
  logic        chk_en = 1'b0;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    if (!resetn) begin
      q.delete();
      flush_left = 0;
      m_br = '0; m_dpc = '0; m_flush = 1'b0; m_res = '0; m_miss = '0;
    end else if (flush_left > 0) begin
      flush_left--;
      m_br = '0;
      m_flush = 1'b0;
    end else begin
      bit   was_full, popped, is_miss;
      rec_t h;
      was_full = (q.size() == DEPTH);
      popped   = 0;
      is_miss  = 0;
      if (ex_valid) begin
        m_res++;
        if (q.size() > 0) begin
          h = q.pop_front();
          popped = 1;
        end else begin
          h.pc = ex_pc; h.bpe = 1'b0; h.tgt = '0;
        end
        if (h.pc != ex_pc) is_miss = 1;
        else if (ex_taken) is_miss = !(h.bpe && h.tgt == ex_target);
        else is_miss = h.bpe;
      end
      if (pd_valid && (!was_full || popped) && !is_miss) begin
        rec_t r;
        r.pc = pd_pc; r.bpe = pd_bus[32]; r.tgt = pd_bus[31:0];
        q.push_back(r);
      end
      if (is_miss) begin
        q.delete();
        flush_left = FLUSH_CYC;
        m_miss++;
        m_br = {1'b1, ex_taken ? ex_target : ex_pc + 32'd4};
        m_dpc = ex_pc;
        m_flush = 1'b1;
      end else begin
        m_br = '0;
        m_flush = 1'b0;
      end
    end
  end

  // compare process
  always @(negedge clk) begin
    if (chk_en) begin
      chk("br_bus", 64'(br_bus), 64'(m_br));
      chk("flush", 64'(flush), 64'(m_flush));
      if (m_br[32]) chk("delayslot_pc", 64'(delayslot_pc), 64'(m_dpc));
      chk("pd_empty", 64'(pd_empty), 64'(q.size() == 0));
      chk("pd_full", 64'(pd_full), 64'(q.size() == DEPTH));
      chk("resolve_cnt", 64'(resolve_cnt), 64'(m_res));
      chk("miss_cnt", 64'(miss_cnt), 64'(m_miss));
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic pv, input logic [31:0] pc, input logic bpe,
                       input logic [31:0] tgt, input logic ev, input logic [31:0] epc,
                       input logic tk, input logic [31:0] etgt);
    pd_valid = pv; pd_pc = pc; pd_bus = {bpe, tgt};
    ex_valid = ev; ex_pc = epc; ex_taken = tk; ex_target = etgt;
    tick();
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic push(input logic [31:0] pc, input logic bpe, input logic [31:0] tgt);
    drive(1, pc, bpe, tgt, 0, 0, 0, 0);
  endtask

  task automatic resolve(input logic [31:0] epc, input logic tk, input logic [31:0] etgt);
    drive(0, 0, 0, 0, 1, epc, tk, etgt);
  endtask

  initial begin
    logic [32:0] lit;
    logic [31:0] pcs[4];
    logic [31:0] tgts[3];
    pcs[0] = 32'h100; pcs[1] = 32'h104; pcs[2] = 32'h108; pcs[3] = 32'h10c;
    tgts[0] = 32'h200; tgts[1] = 32'h300; tgts[2] = 32'h400;

    // reset
    resetn = 1'b0;
    idle(); idle();
    resetn = 1'b1;
    chk_en = 1'b1;
    chk("rst_br_bus", 64'(br_bus), 64'd0);
    chk("rst_dpc", 64'(delayslot_pc), 64'd0);
    chk("rst_empty", 64'(pd_empty), 64'd1);
    chk("rst_full", 64'(pd_full), 64'd0);
    chk("rst_cnts", {resolve_cnt, miss_cnt}, 64'd0);

    // correct taken prediction
    push(32'h100, 1, 32'h200);
    chk("t1_nonempty", 64'(pd_empty), 64'd0);
    resolve(32'h100, 1, 32'h200);
    chk("t1_br_bus", 64'(br_bus), 64'd0);
    chk("t1_flush", 64'(flush), 64'd0);
    chk("t1_res", 64'(resolve_cnt), 64'd1);
    chk("t1_miss", 64'(miss_cnt), 64'd0);

    // predicted not-taken, actually taken
    push(32'h100, 0, 32'h0);
    resolve(32'h100, 1, 32'h400);
    lit = {1'b1, 32'h400};
    chk("t2_br_bus", 64'(br_bus), 64'(lit));
    chk("t2_dpc", 64'(delayslot_pc), 64'h100);
    chk("t2_flush", 64'(flush), 64'd1);
    chk("t2_miss", 64'(miss_cnt), 64'd1);
    chk("t2_empty", 64'(pd_empty), 64'd1);
    idle();
    chk("t2_flush_pulse", 64'(flush), 64'd0);
    chk("t2_br_pulse", 64'(br_bus), 64'd0);

    // predicted taken, actually not taken
    push(32'h104, 1, 32'h300);
    resolve(32'h104, 0, 32'h0);
    lit = {1'b1, 32'h108};
    chk("t3_br_bus", 64'(br_bus), 64'(lit));
    chk("t3_flush", 64'(flush), 64'd1);
    idle();

    // fill, drop when full, push+pop at full, in-order drain
    push(32'h10, 0, 0); push(32'h14, 0, 0); push(32'h18, 0, 0); push(32'h1c, 0, 0);
    chk("t4_full", 64'(pd_full), 64'd1);
    push(32'h20, 0, 0);
    chk("t4_drop_full", 64'(pd_full), 64'd1);
    drive(1, 32'h24, 0, 0, 1, 32'h10, 0, 0);
    chk("t4_pushpop_full", 64'(pd_full), 64'd1);
    chk("t4_pushpop_br", 64'(br_bus), 64'd0);
    resolve(32'h14, 0, 0);
    resolve(32'h18, 0, 0);
    resolve(32'h1c, 0, 0);
    resolve(32'h24, 0, 0);
    chk("t4_drained", 64'(pd_empty), 64'd1);
    chk("t4_miss", 64'(miss_cnt), 64'd2);
    chk("t4_res", 64'(resolve_cnt), 64'd8);

    // miss with a simultaneous push, then traffic during FLUSH
    push(32'h40, 0, 0); push(32'h44, 0, 0); push(32'h48, 0, 0);
    drive(1, 32'h4c, 0, 0, 1, 32'h40, 1, 32'h999);
    chk("t5_empty", 64'(pd_empty), 64'd1);
    chk("t5_miss", 64'(miss_cnt), 64'd3);
    drive(1, 32'h50, 0, 0, 1, 32'h44, 0, 0);
    chk("t5_flush_res", 64'(resolve_cnt), 64'd9);
    chk("t5_flush_empty", 64'(pd_empty), 64'd1);
    idle();
    chk("t5_after_empty", 64'(pd_empty), 64'd1);

    // resolve with empty FIFO, then reset during FLUSH
    resolve(32'h60, 1, 32'h500);
    lit = {1'b1, 32'h500};
    chk("t6_br_bus", 64'(br_bus), 64'(lit));
    chk("t6_res", 64'(resolve_cnt), 64'd10);
    resetn = 1'b0;
    idle();
    chk("t6_rst_br", 64'(br_bus), 64'd0);
    chk("t6_rst_flush", 64'(flush), 64'd0);
    chk("t6_rst_dpc", 64'(delayslot_pc), 64'd0);
    chk("t6_rst_cnts", {resolve_cnt, miss_cnt}, 64'd0);
    chk("t6_rst_empty", 64'(pd_empty), 64'd1);
    resetn = 1'b1;

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      logic        pv, bpe, ev, tk;
      logic [31:0] pc, tgt, epc, etgt;
      resetn = ($urandom_range(0, 199) != 0);
      pv   = ($urandom_range(0, 1) == 1);
      pc   = pcs[$urandom_range(0, 3)];
      bpe  = ($urandom_range(0, 1) == 1);
      tgt  = tgts[$urandom_range(0, 2)];
      ev   = ($urandom_range(0, 9) < 4);
      if (q.size() > 0 && $urandom_range(0, 9) < 8) epc = q[0].pc;
      else epc = pcs[$urandom_range(0, 3)];
      if (q.size() > 0 && q[0].pc == epc && $urandom_range(0, 9) < 7) begin
        tk   = q[0].bpe;
        etgt = q[0].bpe ? q[0].tgt : tgts[$urandom_range(0, 2)];
      end else begin
        tk   = ($urandom_range(0, 1) == 1);
        etgt = tgts[$urandom_range(0, 2)];
      end
      drive(pv, pc, bpe, tgt, ev, epc, tk, etgt);
    end
    resetn = 1'b1;
    idle(); idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
